// File: rtl/replica_ram_stream.sv
// Tour-storage RAM for one replica slot: streams all entries out once per
// command, optionally refilling each from a neighbour replica's stream.
module replica_ram_stream #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 30,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] prev_data,
   input  logic [WIDTH-1:0] folw_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [1:0] C_NOP  = 2'd0;
   localparam logic [1:0] C_PREV = 2'd1;
   localparam logic [1:0] C_READ = 2'd3;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [AW:0]   LIM  = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] ram [DEPTH];

   state_t          state, state_nxt;
   logic [AW-1:0]   count, count_nxt;
   logic [1:0]      mode, mode_nxt;
   logic [1:0]      wmode;
   logic [AW-1:0]   idx;
   logic            accept, proc;
   logic            ram_we;
   logic [AW-1:0]   ram_wa;
   logic [WIDTH-1:0] ram_wd;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         mode  <= C_NOP;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         mode  <= mode_nxt;
      end
   end

   // Entry 0 is handled on the accept edge itself, so mode/index bypass
   // the registers while accepting.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      mode_nxt  = mode;
      accept    = (state == IDLE) && cmd_valid && (cmd != C_NOP);
      proc      = accept || (state == RUN);
      idx       = accept ? '0 : count;
      wmode     = accept ? cmd : mode;
      if (accept) mode_nxt = cmd;
      if (proc) begin
         if (idx == LAST) begin
            state_nxt = IDLE;
            count_nxt = '0;
         end else begin
            state_nxt = RUN;
            count_nxt = idx + 1'b1;
         end
      end
   end

   always_comb begin
      ram_we = 1'b0;
      ram_wa = wr_addr;
      ram_wd = wr_data;
      if (proc) begin
         if (wmode != C_READ) begin
            ram_we = 1'b1;
            ram_wa = idx;
            ram_wd = (wmode == C_PREV) ? prev_data : folw_data;
         end
      end else if (wr_en && ({1'b0, wr_addr} < LIM)) begin
         ram_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && ram_we) ram[ram_wa] <= ram_wd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         rd_data   <= '0;
      end else begin
         out_valid <= proc;
         out_last  <= proc && (idx == LAST);
         if (proc) out_data <= ram[idx];
         rd_data <= ({1'b0, rd_addr} < LIM) ? ram[rd_addr] : '0;
      end
   end

endmodule

// File: tb/tb_replica_ram_stream.sv
// Bench for replica_ram_stream: DEPTH=4 stream scoreboard plus a DEPTH=1
// build for the single-entry corner.
module tb_replica_ram_stream;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'd0;
   logic       cmd_ready;
   logic [7:0] prev_data = 8'd0;
   logic [7:0] folw_data = 8'd0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic [1:0] rd_addr = 2'd0;
   logic [7:0] rd_data;

   logic       one_cmd_valid = 1'b0;
   logic [1:0] one_cmd = 2'd0;
   logic       one_cmd_ready;
   logic [7:0] one_prev_data = 8'd0;
   logic [7:0] one_folw_data = 8'd0;
   logic       one_out_valid;
   logic [7:0] one_out_data;
   logic       one_out_last;
   logic       one_busy;
   logic       one_wr_en = 1'b0;
   logic [0:0] one_wr_addr = 1'b0;
   logic [7:0] one_wr_data = 8'd0;
   logic [0:0] one_rd_addr = 1'b0;
   logic [7:0] one_rd_data;

   replica_ram_stream #(.WIDTH(8), .DEPTH(4)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
      .prev_data(prev_data), .folw_data(folw_data),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .busy(busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   replica_ram_stream #(.WIDTH(8), .DEPTH(1)) u_one (
      .clk(clk), .reset(reset),
      .cmd_valid(one_cmd_valid), .cmd(one_cmd), .cmd_ready(one_cmd_ready),
      .prev_data(one_prev_data), .folw_data(one_folw_data),
      .out_valid(one_out_valid), .out_data(one_out_data),
      .out_last(one_out_last), .busy(one_busy),
      .wr_en(one_wr_en), .wr_addr(one_wr_addr), .wr_data(one_wr_data),
      .rd_addr(one_rd_addr), .rd_data(one_rd_data)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         vcnt = 0;
   logic [8:0] sb [$];
   logic [7:0] m [4];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      wr_en = 1'b1;
      wr_addr = 2'(a);
      wr_data = 8'(d);
      step();
      wr_en = 1'b0;
      m[a] = 8'(d);
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         step();
         chk(tag, rd_data, m[i]);
      end
   endtask

   // Drives one command plus its neighbour stream; expected words are the
   // model's old contents, and the model takes the new ones.
   task automatic run_cmd(input logic [1:0] c, input int pb, input int fb,
                          input bit drop);
      for (int i = 0; i < 4; i++) begin
         cmd_valid = (i == 0);
         cmd = (i == 0) ? c : 2'(i);
         prev_data = 8'(pb + i);
         folw_data = 8'(fb + i);
         wr_en = drop;
         wr_addr = 2'd2;
         wr_data = 8'd99;
         if (i > 0) begin
            chk("ready_run", cmd_ready, 0);
            chk("busy_run", busy, 1);
         end
         sb.push_back({i == 3, m[i]});
         if (c == 2'd1) m[i] = 8'(pb + i);
         else if (c == 2'd2) m[i] = 8'(fb + i);
         step();
      end
      cmd_valid = 1'b0;
      cmd = 2'd0;
      wr_en = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (out_valid) begin
         vcnt++;
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            e = sb.pop_front();
            chk("stream", {out_last, out_data}, e);
         end
      end else begin
         chk("last_idle", out_last, 0);
      end
   end

   initial begin
      int snap;
      logic [7:0] old;

      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", out_data, 0);
      chk("rst_rd", rd_data, 0);
      chk("rst_ready", cmd_ready, 1);
      reset = 1'b1;
      step();

      for (int a = 0; a < 4; a++) wr(a, 10 + a);
      cmd_valid = 1'b1;
      cmd = 2'd0;
      step();
      chk("nop_ignored", busy, 0);
      cmd_valid = 1'b0;

      run_cmd(2'd3, 0, 0, 1'b0);
      sweep("rd_after_read");

      run_cmd(2'd1, 20, 0, 1'b0);
      sweep("rd_after_prev");

      snap = vcnt;
      run_cmd(2'd3, 0, 0, 1'b0);
      run_cmd(2'd2, 50, 30, 1'b0);
      @(negedge clk);
      #1;
      chk("b2b_valid_cnt", 32'(vcnt - snap), 8);
      step();
      sweep("rd_after_folw");

      run_cmd(2'd3, 0, 0, 1'b1);
      sweep("rd_after_drop");

      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         old = m[a];
         wr(a, 10 + a);
         chk("rd_collide", rd_data, old);
      end

      cmd_valid = 1'b1;
      cmd = 2'd1;
      prev_data = 8'd40;
      sb.push_back({1'b0, m[0]});
      m[0] = 8'd40;
      step();
      cmd_valid = 1'b0;
      prev_data = 8'd41;
      m[1] = 8'd41;
      step();
      prev_data = 8'd42;
      reset = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_data", out_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rd", rd_data, 0);
      step();
      reset = 1'b1;
      chk("abort_ready", cmd_ready, 1);
      step();
      sweep("rd_after_abort");

      one_wr_en = 1'b1;
      one_wr_addr = 1'b0;
      one_wr_data = 8'd77;
      step();
      one_wr_addr = 1'b1;
      one_wr_data = 8'd55;
      step();
      one_wr_en = 1'b0;
      one_rd_addr = 1'b1;
      step();
      chk("one_rd_oob", one_rd_data, 0);
      one_rd_addr = 1'b0;
      step();
      chk("one_rd0", one_rd_data, 77);
      one_cmd_valid = 1'b1;
      one_cmd = 2'd3;
      chk("one_ready0", one_cmd_ready, 1);
      step();
      chk("one_valid", one_out_valid, 1);
      chk("one_last", one_out_last, 1);
      chk("one_data", one_out_data, 77);
      chk("one_busy", one_busy, 0);
      chk("one_ready1", one_cmd_ready, 1);
      one_cmd = 2'd2;
      one_folw_data = 8'd88;
      step();
      chk("one_valid2", one_out_valid, 1);
      chk("one_data2", one_out_data, 77);
      chk("one_busy2", one_busy, 0);
      one_cmd_valid = 1'b0;
      step();
      chk("one_idle_valid", one_out_valid, 0);
      chk("one_idle_last", one_out_last, 0);
      chk("one_hold_data", one_out_data, 77);
      chk("one_rd_new", one_rd_data, 88);

      step();
      step();
      chk("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
